// File: rtl/i2c_pkg.sv
// i2c_pkg: definitions shared by the I2C target and the team's I2C controller.
//   i2c_state_e     target FSM state encoding
//   I2C_RW_*        value of the R/W bit that follows the 7-bit address
//   I2C_ACK/NACK    level of SDA during the acknowledge clock
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_RX        = 3'd3,
        ST_RX_ACK    = 3'd4,
        ST_TX        = 3'd5,
        ST_TX_ACK    = 3'd6,
        ST_WAIT_STOP = 3'd7
    } i2c_state_e;

    localparam logic I2C_RW_WRITE = 1'b0;
    localparam logic I2C_RW_READ  = 1'b1;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// i2c_bus_sync: brings SCL/SDA into the clk domain and detects bus events.
//   clk, rst   system clock, synchronous active-high reset
//   scl_i      raw bus clock
//   sda_i      raw bus data
//   scl_rise   1-cycle pulse, synchronised SCL went 0->1
//   scl_fall   1-cycle pulse, synchronised SCL went 1->0
//   start_det  1-cycle pulse, SDA fell while SCL high
//   stop_det   1-cycle pulse, SDA rose while SCL high
//   sda_s      synchronised SDA level
// All flops reset to 1 so the bus looks idle straight out of reset.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_hist_q, scl_hist_d;
    logic                   sda_hist_q, sda_hist_d;
    logic                   scl_cur;
    logic                   sda_cur;

    assign scl_cur = scl_sync_q[SYNC_STAGES-1];
    assign sda_cur = sda_sync_q[SYNC_STAGES-1];

    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_i};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_i};
        scl_hist_d = scl_cur;
        sda_hist_d = sda_cur;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_hist_q <= scl_hist_d;
            sda_hist_q <= sda_hist_d;
        end
    end

    assign scl_rise  = scl_cur & ~scl_hist_q;
    assign scl_fall  = ~scl_cur & scl_hist_q;
    // START/STOP qualify on the current SCL sample, so SCL and SDA rising in
    // the same sample reads as a STOP rather than a data bit.
    assign start_det = sda_hist_q & ~sda_cur & scl_cur;
    assign stop_det  = ~sda_hist_q & sda_cur & scl_cur;
    assign sda_s     = sda_cur;

endmodule

// File: rtl/i2c_target.sv
// i2c_target: single-address I2C target, no clock stretching.
//   clk, rst   system clock (>= 16x SCL), synchronous active-high reset
//   i2c_scl    bus clock, sampled only
//   i2c_sda    bus data, open drain: driven 0 or released, never driven 1
//   rx_data    last byte received in a write transfer
//   rx_valid   1-cycle pulse, rx_data holds a new byte in that cycle
//   tx_data    next byte to send in a read transfer
//   tx_ack     1-cycle pulse, tx_data is captured in that cycle
//   busy       high from an address-matched START until STOP/restart
// Fabric handshake: both strobes are single-cycle pulses with no back-pressure.
// rx_valid qualifies rx_data; tx_ack means tx_data is consumed at the end of
// that cycle, so the fabric must hold the next byte on tx_data at all times.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDR        = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i2c_scl,
    inout  wire        i2c_sda,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ack,
    output logic       busy
);

    logic scl_rise, scl_fall, start_det, stop_det, sda_s;

    i2c_bus_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_bus_sync (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (i2c_scl),
        .sda_i     (i2c_sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_s     (sda_s)
    );

    i2c_state_e state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       byte_done_q, byte_done_d;   // 8 bits shifted, waiting for scl_fall
    logic       rw_q, rw_d;
    logic       busy_q, busy_d;
    logic       sda_oe_q, sda_oe_d;         // 1 = pull SDA low
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic       ack_q, ack_d;               // controller ACK level after a sent byte
    logic       tx_load;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        byte_done_d = byte_done_q;
        rw_d        = rw_q;
        busy_d      = busy_q;
        sda_oe_d    = sda_oe_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        tx_shift_d  = tx_shift_q;
        ack_d       = ack_q;
        tx_load     = 1'b0;

        if (stop_det) begin
            state_d     = ST_IDLE;
            busy_d      = 1'b0;
            sda_oe_d    = 1'b0;
            byte_done_d = 1'b0;
        end else if (start_det) begin
            // Also a repeated START: any partial byte is simply dropped.
            state_d     = ST_ADDR;
            bit_cnt_d   = 3'd0;
            byte_done_d = 1'b0;
            busy_d      = 1'b0;
            sda_oe_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    sda_oe_d = 1'b0;
                end
                ST_ADDR: begin
                    // The first scl_fall after START has byte_done clear and
                    // is ignored; only the fall after bit 8 ends the phase.
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) byte_done_d = 1'b1;
                    end else if (scl_fall && byte_done_q) begin
                        byte_done_d = 1'b0;
                        if (shift_q[7:1] == ADDR) begin
                            sda_oe_d = 1'b1;
                            busy_d   = 1'b1;
                            rw_d     = shift_q[0];
                            state_d  = ST_ADDR_ACK;
                        end else begin
                            state_d  = ST_WAIT_STOP;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (rw_q == I2C_RW_READ) begin
                            tx_load = 1'b1;
                            state_d = ST_TX;
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 3'd0;
                            state_d   = ST_RX;
                        end
                    end
                end
                ST_RX: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) byte_done_d = 1'b1;
                    end else if (scl_fall && byte_done_q) begin
                        byte_done_d = 1'b0;
                        rx_data_d   = shift_q;
                        rx_valid_d  = 1'b1;
                        sda_oe_d    = 1'b1;
                        state_d     = ST_RX_ACK;
                    end
                end
                ST_RX_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 3'd0;
                        state_d   = ST_RX;
                    end
                end
                ST_TX: begin
                    // bit_cnt counts bits already put on the bus after bit7.
                    if (scl_fall) begin
                        if (bit_cnt_q == 3'd7) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 3'd0;
                            state_d   = ST_TX_ACK;
                        end else begin
                            sda_oe_d   = ~tx_shift_q[7];
                            tx_shift_d = {tx_shift_q[6:0], 1'b0};
                            bit_cnt_d  = bit_cnt_q + 3'd1;
                        end
                    end
                end
                ST_TX_ACK: begin
                    if (scl_rise) begin
                        ack_d = sda_s;
                    end else if (scl_fall) begin
                        if (ack_q == I2C_ACK) begin
                            tx_load = 1'b1;
                            state_d = ST_TX;
                        end else begin
                            state_d = ST_WAIT_STOP;
                        end
                    end
                end
                ST_WAIT_STOP: begin
                    sda_oe_d = 1'b0;
                end
                default: begin
                    state_d  = ST_IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase

            // Byte fetch: bit7 goes straight onto the bus from tx_data so the
            // first bit appears one clk after the scl_fall, like every other bit.
            if (tx_load) begin
                tx_shift_d = {tx_data[6:0], 1'b0};
                sda_oe_d   = ~tx_data[7];
                bit_cnt_d  = 3'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            byte_done_q <= 1'b0;
            rw_q        <= I2C_RW_WRITE;
            busy_q      <= 1'b0;
            sda_oe_q    <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            tx_shift_q  <= 8'h00;
            ack_q       <= I2C_NACK;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            byte_done_q <= byte_done_d;
            rw_q        <= rw_d;
            busy_q      <= busy_d;
            sda_oe_q    <= sda_oe_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            tx_shift_q  <= tx_shift_d;
            ack_q       <= ack_d;
        end
    end

    assign i2c_sda  = sda_oe_q ? 1'b0 : 1'bz;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_ack   = tx_load & ~rst;
    assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: behavioural I2C controller (SCL period 32 clk) driving
// i2c_target, with a pull-up on SDA and a byte scoreboard for writes.
module tb_i2c_target;
    import i2c_pkg::*;

    localparam int         Q        = 8;      // quarter SCL period in clk
    localparam logic [6:0] TGT_ADDR = 7'h42;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl = 1'b1;
    logic       m_sda_low = 1'b0;
    logic [7:0] tx_data = 8'h00;
    wire        sda_w;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_ack;
    logic       busy;

    assign sda_w = m_sda_low ? 1'b0 : 1'bz;
    pullup (sda_w);

    i2c_target #(
        .ADDR        (TGT_ADDR),
        .SYNC_STAGES (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i2c_scl  (scl),
        .i2c_sda  (sda_w),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_ack   (tx_ack),
        .busy     (busy)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got no finish, want finish");
        $fatal(1);
    end

    // ---------------- scoreboard and monitors ----------------
    int         n_checks = 0;
    int         n_fail = 0;
    int         rx_cnt = 0;
    int         tx_ack_cnt = 0;
    int         dut_low_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;
    logic       rx_valid_prev = 1'b0;
    logic       tx_ack_prev = 1'b0;

    always @(negedge clk) begin
        if (rx_valid === 1'b1 || tx_ack === 1'b1) begin
            n_checks++;
            if ((rx_valid && tx_ack) || (rx_valid && rx_valid_prev) || (tx_ack && tx_ack_prev)) begin
                n_fail++;
                $display("FAIL strobe_shape: rx_valid=%b tx_ack=%b prev rx_valid=%b prev tx_ack=%b, want single-cycle non-overlapping",
                         rx_valid, tx_ack, rx_valid_prev, tx_ack_prev);
            end
        end
        if (rx_valid === 1'b1) begin
            rx_cnt++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rx_unexpected: got rx_data=%h, want no rx_valid", rx_data);
            end else begin
                exp_b = exp_q.pop_front();
                if (rx_data !== exp_b) begin
                    n_fail++;
                    $display("FAIL rx_data: got %h want %h", rx_data, exp_b);
                end
            end
        end
        if (tx_ack === 1'b1) tx_ack_cnt++;
        if (!m_sda_low && sda_w === 1'b0) dut_low_cnt++;
        rx_valid_prev = rx_valid;
        tx_ack_prev   = tx_ack;
    end

    // ---------------- driver tasks (behavioural controller) ----------------
    task automatic wait_clks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_cond();
        m_sda_low = 1'b0;
        wait_clks(Q);
        scl = 1'b1;
        wait_clks(Q);
        m_sda_low = 1'b1;
        wait_clks(Q);
        scl = 1'b0;
        wait_clks(Q);
    endtask

    task automatic stop_cond();
        m_sda_low = 1'b1;
        wait_clks(Q);
        scl = 1'b1;
        wait_clks(Q);
        m_sda_low = 1'b0;
        wait_clks(Q);
    endtask

    task automatic write_bit(input logic b);
        m_sda_low = ~b;
        wait_clks(Q);
        scl = 1'b1;
        wait_clks(2 * Q);
        scl = 1'b0;
        wait_clks(Q);
    endtask

    task automatic read_bit(output logic b);
        m_sda_low = 1'b0;
        wait_clks(Q);
        scl = 1'b1;
        wait_clks(Q);
        b = sda_w;
        wait_clks(Q);
        scl = 1'b0;
        wait_clks(Q);
    endtask

    task automatic write_byte(input logic [7:0] v, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(v[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] v);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            v[i] = b;
        end
    endtask

    // Controller ACK on a read, then STOP while SCL is still high.
    task automatic ack_then_stop();
        m_sda_low = 1'b1;
        wait_clks(Q);
        scl = 1'b1;
        wait_clks(Q);
        m_sda_low = 1'b0;
        wait_clks(Q);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        scl = 1'b1;
        m_sda_low = 1'b0;
        wait_clks(4);
        n_checks++;
        if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
        n_checks++;
        if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        n_checks++;
        if (tx_ack !== 1'b0) begin n_fail++; $display("FAIL reset_tx_ack: got %b want 0", tx_ack); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++;
        if (sda_w !== 1'b1) begin n_fail++; $display("FAIL reset_sda: got %b want 1", sda_w); end
        rst = 1'b0;
        wait_clks(4);
    endtask

    task automatic test_write();
        logic ack;
        int   r0 = rx_cnt;
        start_cond();
        write_byte({TGT_ADDR, I2C_RW_WRITE}, ack);
        n_checks++;
        if (ack !== I2C_ACK) begin n_fail++; $display("FAIL wr_addr_ack: got %b want 0", ack); end
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL wr_busy: got %b want 1", busy); end
        exp_q.push_back(8'hA5);
        write_byte(8'hA5, ack);
        n_checks++;
        if (ack !== I2C_ACK) begin n_fail++; $display("FAIL wr_data_ack: got %b want 0", ack); end
        stop_cond();
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL wr_busy_stop: got %b want 0", busy); end
        n_checks++;
        if (rx_cnt - r0 != 1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL wr_rx_count: got %0d pulses (%0d pending) want 1 (0 pending)", rx_cnt - r0, exp_q.size());
        end
    endtask

    task automatic test_read();
        logic       ack;
        logic [7:0] d;
        int         t0 = tx_ack_cnt;
        tx_data = 8'h3C;
        start_cond();
        write_byte({TGT_ADDR, I2C_RW_READ}, ack);
        n_checks++;
        if (ack !== I2C_ACK) begin n_fail++; $display("FAIL rd_addr_ack: got %b want 0", ack); end
        n_checks++;
        if (tx_ack_cnt - t0 != 1) begin n_fail++; $display("FAIL rd_tx_ack_first: got %0d want 1", tx_ack_cnt - t0); end
        read_byte(d);
        n_checks++;
        if (d !== 8'h3C) begin n_fail++; $display("FAIL rd_data: got %h want 3c", d); end
        ack_then_stop();
        wait_clks(Q);
        n_checks++;
        if (tx_ack_cnt - t0 != 1) begin n_fail++; $display("FAIL rd_tx_ack_total: got %0d want 1", tx_ack_cnt - t0); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rd_busy_stop: got %b want 0", busy); end
    endtask

    task automatic test_addr_mismatch();
        logic ack;
        int   d0 = dut_low_cnt;
        int   r0 = rx_cnt;
        int   t0 = tx_ack_cnt;
        start_cond();
        write_byte({7'h11, I2C_RW_WRITE}, ack);
        n_checks++;
        if (ack !== I2C_NACK) begin n_fail++; $display("FAIL mm_ack_11: got %b want 1", ack); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL mm_busy: got %b want 0", busy); end
        stop_cond();
        start_cond();
        write_byte({7'h43, I2C_RW_READ}, ack);
        n_checks++;
        if (ack !== I2C_NACK) begin n_fail++; $display("FAIL mm_ack_43: got %b want 1", ack); end
        stop_cond();
        n_checks++;
        if (dut_low_cnt != d0 || rx_cnt != r0 || tx_ack_cnt != t0) begin
            n_fail++;
            $display("FAIL mm_activity: got sda_low=%0d rx=%0d tx=%0d want 0 0 0",
                     dut_low_cnt - d0, rx_cnt - r0, tx_ack_cnt - t0);
        end
    endtask

    task automatic test_multi_write();
        logic       ack;
        logic [7:0] seq[3];
        int         r0 = rx_cnt;
        seq[0] = 8'h01; seq[1] = 8'h80; seq[2] = 8'hFF;
        start_cond();
        write_byte({TGT_ADDR, I2C_RW_WRITE}, ack);
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(seq[k]);
            write_byte(seq[k], ack);
            n_checks++;
            if (ack !== I2C_ACK) begin n_fail++; $display("FAIL mw_ack_%0d: got %b want 0", k, ack); end
        end
        stop_cond();
        n_checks++;
        if (rx_cnt - r0 != 3 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL mw_count: got %0d pulses (%0d pending) want 3 (0 pending)", rx_cnt - r0, exp_q.size());
        end
    endtask

    task automatic test_restart_abort();
        logic ack;
        int   r0 = rx_cnt;
        start_cond();
        write_byte({TGT_ADDR, I2C_RW_WRITE}, ack);
        write_bit(1'b1);
        write_bit(1'b0);
        write_bit(1'b1);
        start_cond();
        write_byte({TGT_ADDR, I2C_RW_WRITE}, ack);
        n_checks++;
        if (ack !== I2C_ACK) begin n_fail++; $display("FAIL rs_addr_ack: got %b want 0", ack); end
        exp_q.push_back(8'h5A);
        write_byte(8'h5A, ack);
        stop_cond();
        n_checks++;
        if (rx_cnt - r0 != 1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rs_count: got %0d pulses (%0d pending) want 1 (0 pending)", rx_cnt - r0, exp_q.size());
        end
    endtask

    task automatic test_rst_mid_rx_ack();
        logic       ack;
        logic [7:0] v = 8'hC3;
        start_cond();
        write_byte({TGT_ADDR, I2C_RW_WRITE}, ack);
        exp_q.push_back(v);
        for (int i = 7; i >= 0; i--) write_bit(v[i]);
        m_sda_low = 1'b0;
        wait_clks(2);
        n_checks++;
        if (sda_w !== 1'b0) begin n_fail++; $display("FAIL rr_ack_driven: got %b want 0", sda_w); end
        rst = 1'b1;
        wait_clks(1);
        n_checks++;
        if (sda_w !== 1'b1 || busy !== 1'b0 || rx_valid !== 1'b0 || tx_ack !== 1'b0 || rx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL rr_after_rst: got sda=%b busy=%b rx_valid=%b tx_ack=%b rx_data=%h want 1 0 0 0 00",
                     sda_w, busy, rx_valid, tx_ack, rx_data);
        end
        rst = 1'b0;
        wait_clks(2);
        stop_cond();
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL rr_pending: got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_sim_rise_stop();
        logic ack;
        int   r0 = rx_cnt;
        start_cond();
        write_byte({TGT_ADDR, I2C_RW_WRITE}, ack);
        exp_q.push_back(8'h77);
        write_byte(8'h77, ack);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL sr_busy_before: got %b want 1", busy); end
        m_sda_low = 1'b1;
        wait_clks(Q);
        scl = 1'b1;
        m_sda_low = 1'b0;
        wait_clks(Q);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL sr_busy_after: got %b want 0", busy); end
        n_checks++;
        if (rx_cnt - r0 != 1) begin n_fail++; $display("FAIL sr_count: got %0d want 1", rx_cnt - r0); end
    endtask

    // Reference model: a transfer is accepted exactly when the address equals
    // TGT_ADDR; accepted writes deliver each byte once in order, accepted
    // reads fetch one byte per data phase the controller starts.
    task automatic test_random(input int n_txn);
        logic       ack;
        logic [6:0] addr;
        logic       rw;
        logic [7:0] bytes[3];
        logic [7:0] d;
        logic       match;
        int         n;
        int         r0, t0;
        for (int t = 0; t < n_txn; t++) begin
            if ($urandom_range(0, 1) == 1) addr = TGT_ADDR;
            else begin
                addr = 7'($urandom_range(0, 127));
                if (addr == TGT_ADDR) addr = addr ^ 7'h01;
            end
            match = (addr == TGT_ADDR);
            rw = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 3);
            for (int k = 0; k < 3; k++) bytes[k] = 8'($urandom_range(0, 255));
            r0 = rx_cnt;
            t0 = tx_ack_cnt;
            tx_data = bytes[0];
            start_cond();
            write_byte({addr, rw}, ack);
            n_checks++;
            if (ack !== (match ? I2C_ACK : I2C_NACK)) begin
                n_fail++;
                $display("FAIL rnd_addr_ack[%0d]: addr=%h got %b want %b", t, addr, ack, !match);
            end
            if (match && rw == I2C_RW_WRITE) begin
                for (int k = 0; k < n; k++) begin
                    exp_q.push_back(bytes[k]);
                    write_byte(bytes[k], ack);
                    n_checks++;
                    if (ack !== I2C_ACK) begin n_fail++; $display("FAIL rnd_wr_ack[%0d.%0d]: got %b want 0", t, k, ack); end
                end
            end else if (match) begin
                for (int k = 0; k < n; k++) begin
                    read_byte(d);
                    n_checks++;
                    if (d !== bytes[k]) begin n_fail++; $display("FAIL rnd_rd_data[%0d.%0d]: got %h want %h", t, k, d, bytes[k]); end
                    if (k < n - 1) begin
                        tx_data = bytes[k + 1];
                        write_bit(I2C_ACK);
                    end else begin
                        write_bit(I2C_NACK);
                    end
                end
            end
            stop_cond();
            n_checks++;
            if (rx_cnt - r0 != ((match && rw == I2C_RW_WRITE) ? n : 0) ||
                tx_ack_cnt - t0 != ((match && rw == I2C_RW_READ) ? n : 0) ||
                busy !== 1'b0 || exp_q.size() != 0) begin
                n_fail++;
                $display("FAIL rnd_summary[%0d]: got rx=%0d tx=%0d busy=%b pending=%0d for addr=%h rw=%b n=%0d",
                         t, rx_cnt - r0, tx_ack_cnt - t0, busy, exp_q.size(), addr, rw, n);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_write();
        test_read();
        test_addr_mismatch();
        test_multi_write();
        test_restart_abort();
        test_rst_mid_rx_ack();
        test_sim_rise_stop();
        test_random(12);
        wait_clks(4);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
